// File: rtl/puf_readout_ctrl_pkg.sv
// Shared sizes and controller state type for the PUF readout path.
// Defaults for SZ_IN, SZ_OUT and CHAL_W are shared with the fifo packer.
package puf_pkg;
  localparam int SZ_IN_DEF  = 8;
  localparam int SZ_OUT_DEF = 264;
  localparam int CHAL_W_DEF = 8;
  localparam int COUNT_DEF  = SZ_OUT_DEF / SZ_IN_DEF;
  localparam int IDX_W      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_WAIT,
    ST_BURST,
    ST_DRAIN,
    ST_HOLD
  } state_e;
endpackage

// File: rtl/puf_readout_ctrl_if.sv
// Host, PUF-core, fifo and consumer signals of the readout controller.
// The controller uses the master modport and its environment uses the slave modport.
interface puf_readout_if import puf_pkg::*; #(
  parameter int SZ_IN  = SZ_IN_DEF,
  parameter int SZ_OUT = SZ_OUT_DEF,
  parameter int CHAL_W = CHAL_W_DEF
);
  logic              req;
  logic [CHAL_W-1:0] chal_base;
  logic              busy;
  logic              err;
  logic [CHAL_W-1:0] puf_chal;
  logic              puf_en;
  logic              puf_done;
  logic [SZ_IN-1:0]  puf_resp;
  logic              fifo_start;
  logic [SZ_IN-1:0]  fifo_data;
  logic              fifo_ready;
  logic [SZ_OUT-1:0] fifo_dout;
  logic              resp_valid;
  logic [SZ_OUT-1:0] resp_data;
  logic              resp_ack;

  modport master (
    input  req, chal_base, puf_done, puf_resp, fifo_ready, fifo_dout, resp_ack,
    output busy, err, puf_chal, puf_en, fifo_start, fifo_data, resp_valid, resp_data
  );

  modport slave (
    output req, chal_base, puf_done, puf_resp, fifo_ready, fifo_dout, resp_ack,
    input  busy, err, puf_chal, puf_en, fifo_start, fifo_data, resp_valid, resp_data
  );
endinterface

// File: rtl/puf_readout_ctrl_buf.sv
// COUNT x SZ_IN response buffer: one synchronous write port and one combinational read port.
module puf_byte_buf import puf_pkg::*; #(
  parameter int SZ_IN = SZ_IN_DEF,
  parameter int COUNT = COUNT_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [SZ_IN-1:0] wr_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [SZ_IN-1:0] rd_data_o
);
  logic [SZ_IN-1:0] mem_q [COUNT];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
endmodule

// File: rtl/puf_readout_ctrl.sv
// Readout sequencer: issues COUNT challenges, buffers the responses, bursts them
// into the fifo packer and presents the packed word on a valid/ack handshake.
module puf_readout_ctrl import puf_pkg::*; #(
  parameter int SZ_IN   = SZ_IN_DEF,
  parameter int SZ_OUT  = SZ_OUT_DEF,
  parameter int CHAL_W  = CHAL_W_DEF,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  puf_readout_if.master bus
);
  localparam int COUNT = SZ_OUT / SZ_IN;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(COUNT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(3);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;
  logic [SZ_OUT-1:0] rdata_q, rdata_d;
  logic [CHAL_W-1:0] chal_q;
  logic              chal_ld;
  logic              buf_we;
  logic [SZ_IN-1:0]  buf_rd;
  logic [CHAL_W-1:0] chal_cur;

  puf_byte_buf #(.SZ_IN(SZ_IN), .COUNT(COUNT)) u_buf (
    .clk       (clk),
    .we_i      (buf_we),
    .wr_idx_i  (idx_q),
    .wr_data_i (bus.puf_resp),
    .rd_idx_i  (idx_q),
    .rd_data_o (buf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Base challenge is only consumed while EVAL/WAIT gate it onto puf_chal.
  always_ff @(posedge clk) begin
    if (chal_ld) chal_q <= bus.chal_base;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    chal_ld = 1'b0;
    buf_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          chal_ld = 1'b1;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        tmr_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (bus.puf_done) begin
          buf_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_BURST;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_EVAL;
          end
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_BURST: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          tmr_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (bus.fifo_ready) begin
          rdata_d = bus.fifo_dout;
          state_d = ST_HOLD;
        end else if (tmr_q == DRAIN_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.resp_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign chal_cur       = chal_q + CHAL_W'(idx_q);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.err        = err_q;
  assign bus.puf_en     = (state_q == ST_EVAL);
  assign bus.puf_chal   = (state_q == ST_EVAL || state_q == ST_WAIT) ? chal_cur : '0;
  assign bus.fifo_start = (state_q == ST_BURST) && (idx_q == '0);
  assign bus.fifo_data  = (state_q == ST_BURST) ? buf_rd : '0;
  assign bus.resp_valid = (state_q == ST_HOLD);
  assign bus.resp_data  = rdata_q;
endmodule

// File: tb/tb_puf_readout_ctrl.sv
// Directed bench for puf_readout_ctrl with a PUF responder, a fifo packer stub
// and a per-cycle transaction model of the expected outputs.
`timescale 1ns/1ps
module tb_puf_readout_ctrl;
  localparam int SZ_IN   = 8;
  localparam int SZ_OUT  = 264;
  localparam int CHAL_W  = 8;
  localparam int TIMEOUT = 20;
  localparam int COUNT   = SZ_OUT / SZ_IN;
  localparam int PUF_LAT = 5;

  typedef logic [SZ_OUT-1:0] wide_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  puf_readout_if #(.SZ_IN(SZ_IN), .SZ_OUT(SZ_OUT), .CHAL_W(CHAL_W)) bus ();

  puf_readout_ctrl #(
    .SZ_IN(SZ_IN), .SZ_OUT(SZ_OUT), .CHAL_W(CHAL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int n_en = 0;
  int n_start = 0;
  bit chk_en = 1'b0;

  logic              exp_busy, exp_err, exp_en, exp_start, exp_valid;
  logic              exp_chal_v, exp_data_v;
  logic [CHAL_W-1:0] exp_chal;
  logic [SZ_IN-1:0]  exp_data;
  wide_t             exp_rdata;
  logic              m_err = 1'b0;

  int                last_lat;
  logic [CHAL_W-1:0] first_chal, last_chal;
  wide_t             last_rdata;

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Per-cycle comparison against the model's expectations for the current cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", wide_t'(bus.busy), wide_t'(exp_busy));
      chk("err", wide_t'(bus.err), wide_t'(exp_err));
      chk("puf_en", wide_t'(bus.puf_en), wide_t'(exp_en));
      if (exp_chal_v) chk("puf_chal", wide_t'(bus.puf_chal), wide_t'(exp_chal));
      chk("fifo_start", wide_t'(bus.fifo_start), wide_t'(exp_start));
      if (exp_data_v) chk("fifo_data", wide_t'(bus.fifo_data), wide_t'(exp_data));
      chk("resp_valid", wide_t'(bus.resp_valid), wide_t'(exp_valid));
      if (exp_valid) chk("resp_data", bus.resp_data, exp_rdata);
    end
    if (bus.puf_en) n_en++;
    if (bus.fifo_start) n_start++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_idle();
    exp_busy = 1'b0; exp_err = m_err; exp_en = 1'b0; exp_start = 1'b0;
    exp_valid = 1'b0; exp_chal_v = 1'b0; exp_data_v = 1'b0;
  endtask

  task automatic set_busy();
    set_idle();
    exp_busy = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      set_idle();
    end
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_busy"}, wide_t'(bus.busy), wide_t'(1'b0));
    chk({tag, "_err"}, wide_t'(bus.err), wide_t'(1'b0));
    chk({tag, "_puf_en"}, wide_t'(bus.puf_en), wide_t'(1'b0));
    chk({tag, "_puf_chal"}, wide_t'(bus.puf_chal), wide_t'(0));
    chk({tag, "_fifo_start"}, wide_t'(bus.fifo_start), wide_t'(1'b0));
    chk({tag, "_fifo_data"}, wide_t'(bus.fifo_data), wide_t'(0));
    chk({tag, "_resp_valid"}, wide_t'(bus.resp_valid), wide_t'(1'b0));
    chk({tag, "_resp_data"}, bus.resp_data, wide_t'(0));
  endtask

  // One readout transaction. silent: challenge the PUF never answers; slow: challenge
  // answered in the last allowed WAIT cycle; ready_at: DRAIN cycle (1..4) of fifo_ready,
  // 0 = never; rst_at: BURST cycle at which reset is forced, -1 = none.
  task automatic readout(input logic [CHAL_W-1:0] base, input int silent, input int slow,
                         input int ack_dly, input bit glitch, input int ready_at,
                         input int rst_at);
    logic [SZ_IN-1:0] bytes [COUNT];
    wide_t pk, epk;
    int t_req, lat;
    bit got;
    set_idle();
    bus.req = 1'b1;
    bus.chal_base = base;
    t_req = cyc_n;
    tick();
    bus.req = 1'b0;
    bus.chal_base = 8'hAA;
    m_err = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      bytes[i] = base + 8'(i) + 8'h11;
      set_busy();
      exp_en = 1'b1; exp_chal_v = 1'b1; exp_chal = base + 8'(i);
      if (i == 0) first_chal = bus.puf_chal;
      if (i == COUNT - 1) last_chal = bus.puf_chal;
      if (glitch && i == 3) begin bus.puf_done = 1'b1; bus.puf_resp = 8'hEE; end
      tick();
      bus.puf_done = 1'b0;
      lat = (i == slow || i == silent) ? TIMEOUT : PUF_LAT;
      for (int w = 1; w <= lat; w++) begin
        set_busy();
        exp_chal_v = 1'b1; exp_chal = base + 8'(i);
        if (i != silent && w == lat) begin
          bus.puf_done = 1'b1;
          bus.puf_resp = bus.puf_chal + 8'h11;
        end
        if (glitch && i == 7 && w == 2) begin bus.req = 1'b1; bus.resp_ack = 1'b1; end
        tick();
        bus.puf_done = 1'b0; bus.req = 1'b0; bus.resp_ack = 1'b0;
      end
      if (i == silent) begin
        m_err = 1'b1;
        set_idle();
        return;
      end
    end
    pk = '0;
    epk = '0;
    for (int k = 0; k < COUNT; k++) begin
      set_busy();
      exp_start = (k == 0); exp_data_v = 1'b1; exp_data = bytes[k];
      epk = {epk[SZ_OUT-SZ_IN-1:0], bytes[k]};
      pk  = {pk[SZ_OUT-SZ_IN-1:0], bus.fifo_data};
      if (glitch && k == 1) begin bus.puf_done = 1'b1; bus.puf_resp = 8'hEE; end
      if (k == rst_at) begin
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        rst_checks("async_rst");
        m_err = 1'b0;
        set_idle();
        tick();
        rst = 1'b0;
        return;
      end
      tick();
      bus.puf_done = 1'b0;
    end
    got = 1'b0;
    for (int n = 1; n <= 4 && !got; n++) begin
      set_busy();
      if (n == ready_at) begin bus.fifo_ready = 1'b1; bus.fifo_dout = pk; got = 1'b1; end
      tick();
      bus.fifo_ready = 1'b0;
      bus.fifo_dout = ~pk;
    end
    if (!got) begin
      m_err = 1'b1;
      set_idle();
      return;
    end
    last_lat = cyc_n - t_req;
    for (int d = 0; d <= ack_dly; d++) begin
      set_busy();
      exp_valid = 1'b1; exp_rdata = epk;
      if (d == 0) last_rdata = bus.resp_data;
      if (d == ack_dly) bus.resp_ack = 1'b1;
      if (glitch && d == 2) bus.req = 1'b1;
      tick();
      bus.resp_ack = 1'b0; bus.req = 1'b0;
    end
    set_idle();
  endtask

  initial begin
    int e0, s0;
    bus.req = 1'b0; bus.chal_base = '0; bus.puf_done = 1'b0; bus.puf_resp = '0;
    bus.fifo_ready = 1'b0; bus.fifo_dout = '0; bus.resp_ack = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_checks("reset");
    rst = 1'b0;
    set_idle();
    chk_en = 1'b1;
    idle(3);

    e0 = n_en; s0 = n_start;
    readout(8'h00, -1, -1, 0, 1'b0, 2, -1);
    idle(2);
    chk("nom_en_pulses", wide_t'(n_en - e0), wide_t'(33));
    chk("nom_start_pulses", wide_t'(n_start - s0), wide_t'(1));
    chk("nom_latency", wide_t'(last_lat), wide_t'(234));
    chk("nom_msb_byte", wide_t'(last_rdata[SZ_OUT-1 -: 8]), wide_t'(8'h11));
    chk("nom_lsb_byte", wide_t'(last_rdata[7:0]), wide_t'(8'h31));

    readout(8'hF0, -1, -1, 3, 1'b0, 2, -1);
    idle(2);
    chk("wrap_first_chal", wide_t'(first_chal), wide_t'(8'hF0));
    chk("wrap_last_chal", wide_t'(last_chal), wide_t'(8'h10));

    s0 = n_start;
    readout(8'h20, 3, -1, 0, 1'b0, 2, -1);
    idle(3);
    chk("timeout_err", wide_t'(bus.err), wide_t'(1'b1));
    chk("timeout_no_start", wide_t'(n_start - s0), wide_t'(0));

    readout(8'h05, -1, 0, 10, 1'b1, 4, -1);
    idle(2);
    chk("glitch_err_cleared", wide_t'(bus.err), wide_t'(1'b0));
    chk("glitch_msb_byte", wide_t'(last_rdata[SZ_OUT-1 -: 8]), wide_t'(8'h16));

    readout(8'h33, -1, -1, 0, 1'b0, 0, -1);
    idle(2);
    chk("drain_timeout_err", wide_t'(bus.err), wide_t'(1'b1));

    readout(8'h40, -1, -1, 0, 1'b0, 2, 10);
    idle(2);
    readout(8'h80, -1, -1, 1, 1'b0, 2, -1);
    idle(2);
    chk("post_rst_msb_byte", wide_t'(last_rdata[SZ_OUT-1 -: 8]), wide_t'(8'h91));
    chk("post_rst_lsb_byte", wide_t'(last_rdata[7:0]), wide_t'(8'hB1));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
